mem_req_arbiter: RTL and testbench



---
 rtl/mem_req_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - arbitrates E-tile load/store requests onto the single D-tile port
//
// Purpose: picks one requester (round-robin or lowest-LSID-first), issues its
// request to the D-tile, waits for ack or timeout, then returns a one-cycle
// response pulse to that requester. Only one D-tile transaction is outstanding.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid/req_is_store         per-requester request and store flag
//   req_lsid/req_addr/req_wdata    flattened per-requester fields (slice i = [i*W +: W])
//   req_ready                      one-hot accept pulse (first ISSUE cycle)
//   rsp_valid                      one-hot response pulse
//   rsp_data/rsp_hit/rsp_err       shared response payload
//   flush                          suppresses the in-flight response
//   d_load_req/d_store_req/d_lsid/d_addr/d_store_data   request to D-tile
//   d_load_data/d_hit/d_ack        reply from D-tile
//   busy                           arbiter is not idle
module mem_req_arbiter #(
    parameter int NUM_REQ  = 16,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int LSID_W   = 5,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_is_store,
    input  logic [NUM_REQ*LSID_W-1:0] req_lsid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_hit,
    output logic                      rsp_err,
    input  logic                      flush,
    output logic                      d_load_req,
    output logic                      d_store_req,
    output logic [LSID_W-1:0]         d_lsid,
    output logic [ADDR_W-1:0]         d_addr,
    output logic [DATA_W-1:0]         d_store_data,
    input  logic [DATA_W-1:0]         d_load_data,
    input  logic                      d_hit,
    input  logic                      d_ack,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]   NUM_REQ_L = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic [CNT_W-1:0]   to_cnt;
    logic               flush_pend;
    logic               iss_store;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [LSID_W-1:0]  best_lsid;
    logic [IDX_W:0]     rr_sum;
    logic [IDX_W-1:0]   rr_idx;

    // Winner selection. Strict less-than in LSID mode keeps ties on the lower index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        best_lsid = '0;
        rr_sum    = '0;
        rr_idx    = '0;
        if (ARB_MODE == 1) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] &&
                    (!win_found || req_lsid[i*LSID_W +: LSID_W] < best_lsid)) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(i);
                    best_lsid = req_lsid[i*LSID_W +: LSID_W];
                end
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                rr_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
                if (rr_sum >= NUM_REQ_L) begin
                    rr_sum = rr_sum - NUM_REQ_L;
                end
                rr_idx = rr_sum[IDX_W-1:0];
                if (!win_found && req_valid[rr_idx]) begin
                    win_found = 1'b1;
                    win_idx   = rr_idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            to_cnt       <= '0;
            flush_pend   <= 1'b0;
            iss_store    <= 1'b0;
            req_ready    <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_hit      <= 1'b0;
            rsp_err      <= 1'b0;
            d_load_req   <= 1'b0;
            d_store_req  <= 1'b0;
            d_lsid       <= '0;
            d_addr       <= '0;
            d_store_data <= '0;
            busy         <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    flush_pend <= 1'b0;
                    if (win_found) begin
                        grant_idx    <= win_idx;
                        iss_store    <= req_is_store[win_idx];
                        d_lsid       <= req_lsid[int'(win_idx)*LSID_W +: LSID_W];
                        d_addr       <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                        d_store_data <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                        d_load_req   <= ~req_is_store[win_idx];
                        d_store_req  <= req_is_store[win_idx];
                        req_ready    <= NUM_REQ'(1) << win_idx;
                        to_cnt       <= '0;
                        busy         <= 1'b1;
                        if (ARB_MODE == 0) begin
                            rr_ptr <= (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    // Ack on the last counted cycle wins over the timeout.
                    if (d_ack || to_cnt == CNT_LAST) begin
                        d_load_req  <= 1'b0;
                        d_store_req <= 1'b0;
                        // The flush seen this very cycle must also suppress the pulse.
                        if (!(flush_pend || flush)) begin
                            rsp_valid <= NUM_REQ'(1) << grant_idx;
                        end
                        if (d_ack) begin
                            rsp_data <= iss_store ? '0 : d_load_data;
                            rsp_hit  <= d_hit;
                            rsp_err  <= 1'b0;
                        end else begin
                            rsp_data <= '0;
                            rsp_hit  <= 1'b0;
                            rsp_err  <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    rsp_data <= '0;
                    rsp_hit  <= 1'b0;
                    rsp_err  <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;

    localparam int NR = 16;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int LW = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_is_store;
    logic [NR*LW-1:0]   req_lsid;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdata;
    logic               flush;
    logic [DW-1:0]      d_load_data;
    logic               d_hit;
    logic               d_ack;

    logic [NR-1:0]      rr_ready, rr_rsp_valid, ls_ready, ls_rsp_valid;
    logic [DW-1:0]      rr_rsp_data, ls_rsp_data, rr_d_store_data, ls_d_store_data;
    logic               rr_rsp_hit, rr_rsp_err, ls_rsp_hit, ls_rsp_err;
    logic               rr_d_load_req, rr_d_store_req, ls_d_load_req, ls_d_store_req;
    logic [LW-1:0]      rr_d_lsid, ls_d_lsid;
    logic [AW-1:0]      rr_d_addr, ls_d_addr;
    logic               rr_busy, ls_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LSID_W(LW),
                      .ARB_MODE(0), .TIMEOUT(8)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_is_store(req_is_store),
        .req_lsid(req_lsid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rr_ready), .rsp_valid(rr_rsp_valid), .rsp_data(rr_rsp_data),
        .rsp_hit(rr_rsp_hit), .rsp_err(rr_rsp_err), .flush(flush),
        .d_load_req(rr_d_load_req), .d_store_req(rr_d_store_req), .d_lsid(rr_d_lsid),
        .d_addr(rr_d_addr), .d_store_data(rr_d_store_data), .d_load_data(d_load_data),
        .d_hit(d_hit), .d_ack(d_ack), .busy(rr_busy)
    );

    mem_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LSID_W(LW),
                      .ARB_MODE(1), .TIMEOUT(8)) u_lsid (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_is_store(req_is_store),
        .req_lsid(req_lsid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(ls_ready), .rsp_valid(ls_rsp_valid), .rsp_data(ls_rsp_data),
        .rsp_hit(ls_rsp_hit), .rsp_err(ls_rsp_err), .flush(flush),
        .d_load_req(ls_d_load_req), .d_store_req(ls_d_store_req), .d_lsid(ls_d_lsid),
        .d_addr(ls_d_addr), .d_store_data(ls_d_store_data), .d_load_data(d_load_data),
        .d_hit(d_hit), .d_ack(d_ack), .busy(ls_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic st, input logic [LW-1:0] lsid,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req_valid[i]            = 1'b1;
        req_is_store[i]         = st;
        req_lsid[i*LW +: LW]    = lsid;
        req_addr[i*AW +: AW]    = addr;
        req_wdata[i*DW +: DW]   = wd;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        req_valid    = '0;
        req_is_store = '0;
        req_lsid     = '0;
        req_addr     = '0;
        req_wdata    = '0;
        flush        = 1'b0;
        d_load_data  = '0;
        d_hit        = 1'b0;
        d_ack        = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Bounded wait for the next accept pulse on the chosen instance.
    task automatic wait_grant(input string tag, input logic use_lsid, input int exp);
        logic [NR-1:0] rdy;
        rdy = '0;
        for (int n = 0; n < 8; n++) begin
            step();
            rdy = use_lsid ? ls_ready : rr_ready;
            if (rdy != '0) break;
        end
        chk(tag, 64'(rdy), 64'(NR'(1) << exp));
    endtask

    initial begin
        int cnt;

        do_reset();
        rst_n = 1'b0;
        chk("rst_ready", 64'(rr_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rr_rsp_valid), 64'h0);
        chk("rst_busy", 64'(rr_busy), 64'h0);
        chk("rst_d_req", 64'({rr_d_load_req, rr_d_store_req}), 64'h0);
        chk("rst_d_addr", 64'(rr_d_addr), 64'h0);
        rst_n = 1'b1;

        // Single load, ack two cycles after issue.
        set_req(5, 1'b0, 5'd3, 32'h100, 64'h0);
        step();
        chk("ld_ready", 64'(rr_ready), 64'h20);
        chk("ld_d_load_req", 64'(rr_d_load_req), 64'h1);
        chk("ld_d_addr", 64'(rr_d_addr), 64'h100);
        chk("ld_d_lsid", 64'(rr_d_lsid), 64'h3);
        req_valid = '0;
        step();
        chk("ld_ready_pulse", 64'(rr_ready), 64'h0);
        chk("ld_req_hold", 64'(rr_d_load_req), 64'h1);
        step();
        d_ack = 1'b1; d_load_data = 64'hDEAD; d_hit = 1'b1;
        step();
        d_ack = 1'b0;
        chk("ld_rsp_valid", 64'(rr_rsp_valid), 64'h20);
        chk("ld_rsp_data", rr_rsp_data, 64'hDEAD);
        chk("ld_rsp_hit", 64'(rr_rsp_hit), 64'h1);
        chk("ld_rsp_err", 64'(rr_rsp_err), 64'h0);
        chk("ld_d_req_drop", 64'(rr_d_load_req), 64'h0);
        step();
        chk("ld_rsp_pulse", 64'(rr_rsp_valid), 64'h0);
        chk("ld_busy_drop", 64'(rr_busy), 64'h0);

        // Round-robin fairness with continuous requests and immediate acks.
        do_reset();
        d_ack = 1'b1;
        set_req(0, 1'b0, 5'd0, 32'h0, 64'h0);
        set_req(3, 1'b0, 5'd0, 32'h0, 64'h0);
        set_req(15, 1'b0, 5'd0, 32'h0, 64'h0);
        wait_grant("rr_g0", 1'b0, 0);
        wait_grant("rr_g1", 1'b0, 3);
        wait_grant("rr_g2", 1'b0, 15);
        chk("rr_ptr_wrap", 64'(u_rr.rr_ptr), 64'h0);
        wait_grant("rr_g3", 1'b0, 0);

        // LSID ordering; each winner drops its request once accepted.
        do_reset();
        d_ack = 1'b1;
        set_req(2, 1'b0, 5'd7, 32'h0, 64'h0);
        set_req(9, 1'b0, 5'd1, 32'h0, 64'h0);
        set_req(11, 1'b0, 5'd1, 32'h0, 64'h0);
        wait_grant("ls_g0", 1'b1, 9);
        req_valid[9] = 1'b0;
        wait_grant("ls_g1", 1'b1, 11);
        req_valid[11] = 1'b0;
        wait_grant("ls_g2", 1'b1, 2);
        req_valid[2] = 1'b0;

        // Store path: load data on the bus must not leak into the response.
        do_reset();
        set_req(4, 1'b1, 5'd2, 32'h40, 64'h1234);
        step();
        chk("st_ready", 64'(rr_ready), 64'h10);
        chk("st_d_req", 64'({rr_d_store_req, rr_d_load_req}), 64'h2);
        chk("st_d_data", rr_d_store_data, 64'h1234);
        chk("st_d_addr", 64'(rr_d_addr), 64'h40);
        req_valid = '0;
        d_ack = 1'b1; d_load_data = 64'hFFFF; d_hit = 1'b1;
        step();
        d_ack = 1'b0;
        chk("st_rsp_valid", 64'(rr_rsp_valid), 64'h10);
        chk("st_rsp_data", rr_rsp_data, 64'h0);
        chk("st_rsp_hit", 64'(rr_rsp_hit), 64'h1);

        // Timeout with no ack, then a normal request.
        do_reset();
        d_load_data = 64'hBAD; d_hit = 1'b1;
        set_req(1, 1'b0, 5'd0, 32'h8, 64'h0);
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            req_valid = '0;
            if (rr_rsp_valid != '0) break;
            if (rr_d_load_req) cnt++;
        end
        chk("to_cycles", 64'(cnt), 64'd8);
        chk("to_rsp_valid", 64'(rr_rsp_valid), 64'h2);
        chk("to_rsp_err", 64'(rr_rsp_err), 64'h1);
        chk("to_rsp_data", rr_rsp_data, 64'h0);
        chk("to_rsp_hit", 64'(rr_rsp_hit), 64'h0);
        step();
        set_req(2, 1'b0, 5'd0, 32'hC, 64'h0);
        step();
        chk("to_next_ready", 64'(rr_ready), 64'h4);
        req_valid = '0;
        d_ack = 1'b1; d_load_data = 64'h55;
        step();
        d_ack = 1'b0;
        chk("to_next_rsp", 64'(rr_rsp_valid), 64'h4);
        chk("to_next_data", rr_rsp_data, 64'h55);
        chk("to_next_err", 64'(rr_rsp_err), 64'h0);

        // Ack on the last counted cycle is a success.
        step();
        set_req(3, 1'b0, 5'd0, 32'h10, 64'h0);
        step();
        req_valid = '0;
        for (int n = 0; n < 7; n++) step();
        chk("edge_still_issue", 64'(rr_d_load_req), 64'h1);
        d_ack = 1'b1; d_load_data = 64'h66; d_hit = 1'b0;
        step();
        d_ack = 1'b0;
        chk("edge_rsp_valid", 64'(rr_rsp_valid), 64'h8);
        chk("edge_rsp_err", 64'(rr_rsp_err), 64'h0);
        chk("edge_rsp_data", rr_rsp_data, 64'h66);

        // Flush during ISSUE suppresses the response; next request is served.
        do_reset();
        set_req(6, 1'b0, 5'd0, 32'h20, 64'h0);
        step();
        chk("fl_ready", 64'(rr_ready), 64'h40);
        req_valid = '0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        d_ack = 1'b1; d_load_data = 64'h99; d_hit = 1'b1;
        step();
        d_ack = 1'b0;
        chk("fl_no_rsp", 64'(rr_rsp_valid), 64'h0);
        chk("fl_busy_resp", 64'(rr_busy), 64'h1);
        set_req(7, 1'b0, 5'd0, 32'h24, 64'h0);
        step();
        chk("fl_busy_drop", 64'(rr_busy), 64'h0);
        step();
        chk("fl_next_ready", 64'(rr_ready), 64'h80);
        req_valid = '0;
        d_ack = 1'b1; d_load_data = 64'h77;
        step();
        d_ack = 1'b0;
        chk("fl_next_rsp", 64'(rr_rsp_valid), 64'h80);
        chk("fl_next_data", rr_rsp_data, 64'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
